// File: rtl/memory_access_unit.sv
// Initiator for a 32-bit single-port RAM: aligns byte/half/word requests onto lanes,
// rejects misaligned or illegal sizes, and returns one extended response per request.
module memory_access_unit #(
  parameter int BYTE_ADDR_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [1:0]                 req_size_i,
  input  logic                       req_unsigned_i,
  input  logic [BYTE_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]                req_wdata_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [31:0]                rsp_rdata_o,
  output logic                       rsp_error_o,
  output logic                       mem_chip_select_o,
  output logic                       mem_wen_o,
  output logic [3:0]                 mem_wmask_o,
  output logic [BYTE_ADDR_WIDTH-3:0] mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  input  logic [31:0]                mem_rdata_i
);

  localparam int WAW = BYTE_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_e;

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       lane_q, lane_d;
  logic             cs_q, cs_d;
  logic             wen_q, wen_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [WAW-1:0]   maddr_q, maddr_d;
  logic [31:0]      mwdata_q, mwdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_error_q, rsp_error_d;

  logic             illegal;
  logic [3:0]       lane_wmask;
  logic [31:0]      lane_wdata;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;

  assign illegal = (req_size_i == 2'b11)
                 | ((req_size_i == 2'b01) & req_addr_i[0])
                 | ((req_size_i == 2'b10) & (|req_addr_i[1:0]));

  always_comb begin
    lane_wmask = 4'b1111;
    lane_wdata = req_wdata_i;
    case (req_size_i)
      2'b00: begin
        lane_wmask = 4'b0001 << req_addr_i[1:0];
        lane_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        lane_wmask = req_addr_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Read-side lane select uses the offset captured at accept time.
  always_comb begin
    ld_byte = mem_rdata_i[{lane_q, 3'b000} +: 8];
    ld_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    cs_d        = cs_q;
    wen_d       = wen_q;
    wmask_d     = wmask_q;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          wr_d   = req_write_i;
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          lane_d = req_addr_i[1:0];
          if (illegal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d  = ACCESS;
            cs_d     = 1'b1;
            wen_d    = req_write_i;
            wmask_d  = req_write_i ? lane_wmask : 4'b0000;
            maddr_d  = req_addr_i[BYTE_ADDR_WIDTH-1:2];
            mwdata_d = lane_wdata;
          end
        end
      end
      ACCESS: begin
        cs_d    = 1'b0;
        wen_d   = 1'b0;
        wmask_d = 4'b0000;
        if (wr_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = 32'h0;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b0;
        rsp_rdata_d = ld_ext;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Async reset drops chip select at once, so a store caught in ACCESS is never written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      cs_q        <= 1'b0;
      wen_q       <= 1'b0;
      wmask_q     <= 4'b0000;
      maddr_q     <= '0;
      mwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      cs_q        <= cs_d;
      wen_q       <= wen_d;
      wmask_q     <= wmask_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready_o       = (state_q == IDLE);
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_rdata_o       = rsp_rdata_q;
  assign rsp_error_o       = rsp_error_q;
  assign mem_chip_select_o = cs_q;
  assign mem_wen_o         = wen_q;
  assign mem_wmask_o       = wmask_q;
  assign mem_addr_o        = maddr_q;
  assign mem_wdata_o       = mwdata_q;

endmodule
